// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light timing path: default timing
// parameters, per-channel state encoding and the 7-segment digit patterns
// (active-low, segment order a..g, MSB = a) used by the light LEDs.
package traffic_pkg;

    localparam int DEF_CLK_FREQ = 50000000;
    localparam int DEF_T_SHORT  = 3;
    localparam int DEF_T_LONG   = 25;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    // Decimal digit to active-low 7-segment pattern; non-digits blank.
    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = 7'b1111111;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/traffic_timer_if.sv
// Start/timeout/busy bundle between the country-road light controller
// (master) and traffic_timer (slave).
// Optional: TRAFFIC_TIMER_DISPLAY_EN adds the sec_left_T display pattern.
interface traffic_timer_if;

    logic       start_t;
    logic       start_T;
    logic       t_timeout;
    logic       T_timeout;
    logic       busy_t;
    logic       busy_T;
`ifdef TRAFFIC_TIMER_DISPLAY_EN
    logic [6:0] sec_left_T;
`endif

    modport master (
        output start_t,
        output start_T,
        input  t_timeout,
        input  T_timeout,
        input  busy_t,
        input  busy_T
`ifdef TRAFFIC_TIMER_DISPLAY_EN
        ,
        input  sec_left_T
`endif
    );

    modport slave (
        input  start_t,
        input  start_T,
        output t_timeout,
        output T_timeout,
        output busy_t,
        output busy_T
`ifdef TRAFFIC_TIMER_DISPLAY_EN
        ,
        output sec_left_T
`endif
    );

endinterface

// File: rtl/one_shot_timer.sv
// Restartable one-shot timer counting DURATION seconds of CLK_FREQ cycles.
// A start pulse (re)loads the interval; at the end a single-cycle timeout
// is produced unless a start arrives on the same edge, which restarts.
// Optional: TRAFFIC_TIMER_DISPLAY_EN exposes the next-cycle seconds value
// so a display register can change on the same edge as the counter.
module one_shot_timer
    import traffic_pkg::*;
#(
    parameter  int CLK_FREQ = DEF_CLK_FREQ,
    parameter  int DURATION = DEF_T_SHORT,
    localparam int PRE_W    = $clog2(CLK_FREQ),
    localparam int SEC_W    = $clog2(DURATION + 1)
) (
    input  logic             clk,
    input  logic             glob_rst,
    input  logic             start,
    output logic             timeout,
    output logic             busy
`ifdef TRAFFIC_TIMER_DISPLAY_EN
    ,
    output logic [SEC_W-1:0] sec_next
`endif
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ - 1);
    localparam logic [SEC_W-1:0] SEC_LOAD = SEC_W'(DURATION);

    chan_state_t      state_r;
    chan_state_t      state_s;
    logic [PRE_W-1:0] pre_r;
    logic [PRE_W-1:0] pre_s;
    logic [SEC_W-1:0] sec_r;
    logic [SEC_W-1:0] sec_s;
    logic             timeout_r;
    logic             timeout_s;
    logic             busy_r;
    logic             busy_s;

    // Next-state logic: load on start, count prescaler, decrement seconds.
    always_comb begin
        state_s   = state_r;
        pre_s     = pre_r;
        sec_s     = sec_r;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                    pre_s   = {PRE_W{1'b0}};
                    sec_s   = SEC_LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (start) begin
                    // Restart abandons the current interval silently.
                    pre_s = {PRE_W{1'b0}};
                    sec_s = SEC_LOAD;
                end else if (pre_r == PRE_LAST) begin
                    pre_s = {PRE_W{1'b0}};
                    // <= 1 rather than == 1 so sec can never underflow.
                    if (sec_r <= SEC_W'(1)) begin
                        state_s   = IDLE;
                        sec_s     = {SEC_W{1'b0}};
                        timeout_s = 1'b1;
                    end else begin
                        sec_s = sec_r - SEC_W'(1);
                    end
                end else begin
                    pre_s = pre_r + PRE_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                pre_s   = {PRE_W{1'b0}};
                sec_s   = {SEC_W{1'b0}};
            end
        endcase
        busy_s = (state_s == RUN);
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (glob_rst) begin
            state_r   <= IDLE;
            pre_r     <= {PRE_W{1'b0}};
            sec_r     <= {SEC_W{1'b0}};
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            pre_r     <= pre_s;
            sec_r     <= sec_s;
            timeout_r <= timeout_s;
            busy_r    <= busy_s;
        end
    end

    assign timeout = timeout_r;
    assign busy    = busy_r;

`ifdef TRAFFIC_TIMER_DISPLAY_EN
    assign sec_next = sec_s;
`endif

endmodule

// File: rtl/traffic_timer.sv
// Dual one-shot second timer for the country-road light controller:
// the t channel times the yellow phase (T_SHORT s), the T channel the
// green phase (T_LONG s). The channels are independent.
// Optional: TRAFFIC_TIMER_DISPLAY_EN adds sec_left_T, the active-low
// 7-segment pattern of the T-channel seconds remaining mod 10.
module traffic_timer
    import traffic_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int T_SHORT  = DEF_T_SHORT,
    parameter int T_LONG   = DEF_T_LONG
) (
    input  logic           clk,
    input  logic           glob_rst,
    traffic_timer_if.slave bus
);

`ifdef TRAFFIC_TIMER_DISPLAY_EN
    localparam int SEC_W_T = $clog2(T_LONG + 1);

    logic [SEC_W_T-1:0] sec_next_T_s;
    logic [6:0]         seg_r;
    logic [3:0]         digit_s;
`endif

    one_shot_timer #(
        .CLK_FREQ (CLK_FREQ),
        .DURATION (T_SHORT)
    ) u_short (
        .clk      (clk),
        .glob_rst (glob_rst),
        .start    (bus.start_t),
        .timeout  (bus.t_timeout),
        .busy     (bus.busy_t)
`ifdef TRAFFIC_TIMER_DISPLAY_EN
        ,
        .sec_next ()
`endif
    );

    one_shot_timer #(
        .CLK_FREQ (CLK_FREQ),
        .DURATION (T_LONG)
    ) u_long (
        .clk      (clk),
        .glob_rst (glob_rst),
        .start    (bus.start_T),
        .timeout  (bus.T_timeout),
        .busy     (bus.busy_T)
`ifdef TRAFFIC_TIMER_DISPLAY_EN
        ,
        .sec_next (sec_next_T_s)
`endif
    );

`ifdef TRAFFIC_TIMER_DISPLAY_EN
    // Units digit of the seconds value the long counter takes next edge.
    always_comb begin
        digit_s = 4'(int'(sec_next_T_s) % 10);
    end

    // Display register follows the seconds counter on the same edge.
    always_ff @(posedge clk) begin
        if (glob_rst) begin
            seg_r <= SEG_0;
        end else begin
            seg_r <= seg7_encode(digit_s);
        end
    end

    assign bus.sec_left_T = seg_r;
`endif

endmodule

// File: tb/tb_traffic_timer.sv
// Directed self-checking bench for traffic_timer (CLK_FREQ=4, T_SHORT=2,
// T_LONG=5). Cycle 0 is the first cycle after reset release; a start
// driven in cycle c is sampled at the edge that opens cycle c+1.
module tb_traffic_timer;

    logic clk;
    logic glob_rst;
    int   total;
    int   bad;

    traffic_timer_if bus ();

    traffic_timer #(
        .CLK_FREQ (4),
        .T_SHORT  (2),
        .T_LONG   (5)
    ) dut (
        .clk      (clk),
        .glob_rst (glob_rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset for three edges, then release with inputs quiet.
    task automatic reset_dut();
        glob_rst    = 1'b1;
        bus.start_t = 1'b0;
        bus.start_T = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        glob_rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        reset_dut();
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            got = {bus.t_timeout, bus.T_timeout, bus.busy_t, bus.busy_T};
            total++;
            if (got !== 4'b0000) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: got %b want %b", c, got, 4'b0000);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_long_single();
        logic [3:0] got;
        logic [3:0] exp;
        reset_dut();
        for (int c = 0; c <= 40; c++) begin
            bus.start_T = (c == 10);
            @(negedge clk);
            got = {bus.t_timeout, bus.T_timeout, bus.busy_t, bus.busy_T};
            exp = {1'b0, (c == 31), 1'b0, (c >= 11 && c <= 30)};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL long_single cycle %0d: got %b want %b", c, got, exp);
            end
            @(posedge clk);
            #1;
        end
        bus.start_T = 1'b0;
    endtask

    task automatic test_short_restart();
        logic [3:0] got;
        logic [3:0] exp;
        reset_dut();
        for (int c = 0; c <= 25; c++) begin
            bus.start_t = (c == 5) || (c == 9);
            @(negedge clk);
            got = {bus.t_timeout, bus.T_timeout, bus.busy_t, bus.busy_T};
            exp = {(c == 18), 1'b0, (c >= 6 && c <= 17), 1'b0};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL short_restart cycle %0d: got %b want %b", c, got, exp);
            end
            @(posedge clk);
            #1;
        end
        bus.start_t = 1'b0;
    endtask

    task automatic test_both_start();
        logic [3:0] got;
        logic [3:0] exp;
        reset_dut();
        for (int c = 0; c <= 30; c++) begin
            bus.start_t = (c == 0);
            bus.start_T = (c == 0);
            @(negedge clk);
            got = {bus.t_timeout, bus.T_timeout, bus.busy_t, bus.busy_T};
            exp = {(c == 9), (c == 21), (c >= 1 && c <= 8), (c >= 1 && c <= 20)};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL both_start cycle %0d: got %b want %b", c, got, exp);
            end
            @(posedge clk);
            #1;
        end
        bus.start_t = 1'b0;
        bus.start_T = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [3:0] got;
        logic [3:0] exp;
        reset_dut();
        for (int c = 0; c <= 40; c++) begin
            bus.start_T = (c == 0);
            glob_rst    = (c == 12);
            @(negedge clk);
            got = {bus.t_timeout, bus.T_timeout, bus.busy_t, bus.busy_T};
            exp = {1'b0, 1'b0, 1'b0, (c >= 1 && c <= 12)};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL mid_reset cycle %0d: got %b want %b", c, got, exp);
            end
            @(posedge clk);
            #1;
        end
        bus.start_T = 1'b0;
        glob_rst    = 1'b0;
    endtask

    task automatic test_terminal_restart();
        logic [3:0] got;
        logic [3:0] exp;
        reset_dut();
        for (int c = 0; c <= 25; c++) begin
            bus.start_t = (c == 0) || (c == 8);
            @(negedge clk);
            got = {bus.t_timeout, bus.T_timeout, bus.busy_t, bus.busy_T};
            exp = {(c == 17), 1'b0, (c >= 1 && c <= 16), 1'b0};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL terminal_restart cycle %0d: got %b want %b", c, got, exp);
            end
            @(posedge clk);
            #1;
        end
        bus.start_t = 1'b0;
    endtask

`ifdef TRAFFIC_TIMER_DISPLAY_EN
    task automatic test_display();
        logic [6:0] pat [0:9];
        logic [6:0] exp;
        int         digit;
        pat[0] = 7'b0000001; pat[1] = 7'b1001111; pat[2] = 7'b0010010;
        pat[3] = 7'b0000110; pat[4] = 7'b1001100; pat[5] = 7'b0100100;
        pat[6] = 7'b0100000; pat[7] = 7'b0001111; pat[8] = 7'b0000000;
        pat[9] = 7'b0000100;
        reset_dut();
        for (int c = 0; c <= 26; c++) begin
            bus.start_T = (c == 0);
            @(negedge clk);
            if (c >= 1 && c <= 20) digit = 5 - ((c - 1) / 4);
            else                   digit = 0;
            exp = pat[digit];
            total++;
            if (bus.sec_left_T !== exp) begin
                bad++;
                $display("FAIL display cycle %0d: got %b want %b", c, bus.sec_left_T, exp);
            end
            @(posedge clk);
            #1;
        end
        bus.start_T = 1'b0;
    endtask
`endif

    initial begin
        total       = 0;
        bad         = 0;
        glob_rst    = 1'b1;
        bus.start_t = 1'b0;
        bus.start_T = 1'b0;
        test_reset();
        test_long_single();
        test_short_restart();
        test_both_start();
        test_mid_reset();
        test_terminal_restart();
`ifdef TRAFFIC_TIMER_DISPLAY_EN
        test_display();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
